// File: rtl/l1_dcache.sv
// l1_dcache: direct-mapped, write-back, write-allocate L1 data cache sitting
// between the core's MEM stage and the main-memory model. Hits complete in
// the request cycle; misses stall, write back a dirty victim, refill the line
// and then let the held request complete as a hit.
module l1_dcache #(
  parameter int LINES = 64,
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [3:0]          cpu_be,
  input  logic [31:0]         cpu_addr,
  input  logic [31:0]         cpu_wdata,
  output logic [31:0]         cpu_rdata,
  output logic                cpu_stall,
  output logic                mem_req,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  output logic [32*WORDS-1:0] mem_wdata,
  input  logic                mem_ack,
  input  logic [32*WORDS-1:0] mem_rdata,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count
);

  localparam int OFF_W  = $clog2(WORDS);
  localparam int IDX_W  = $clog2(LINES);
  localparam int LOW_W  = OFF_W + 2;
  localparam int TAG_W  = 32 - IDX_W - LOW_W;
  localparam int LINE_W = 32 * WORDS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_FILL,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic [LINES-1:0]    dirty_q, dirty_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [31:0]         hit_count_q, hit_count_d;
  logic [31:0]         miss_count_q, miss_count_d;
  // High in the first IDLE cycle after a refill: that hit was already a miss.
  logic                after_done_q, after_done_d;

  // Tag and data storage; written through a single line-wide port.
  logic [TAG_W-1:0]    tag_mem  [LINES];
  logic [LINE_W-1:0]   data_mem [LINES];
  logic                line_we;
  logic                tag_we;
  logic [LINE_W-1:0]   line_wdata;

  // Request address fields.
  logic [OFF_W-1:0]    req_off;
  logic [IDX_W-1:0]    req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic                unused_addr_bits;

  assign req_off          = cpu_addr[LOW_W-1:2];
  assign req_idx          = cpu_addr[LOW_W +: IDX_W];
  assign req_tag          = cpu_addr[31 -: TAG_W];
  assign unused_addr_bits = ^cpu_addr[1:0];

  // Lookup of the indexed line.
  logic [LINE_W-1:0]   cur_line;
  logic [TAG_W-1:0]    cur_tag;
  logic [31:0]         cur_word;
  logic                hit;
  logic [31:0]         victim_addr;
  logic [31:0]         fill_addr;
  logic [LINE_W-1:0]   store_line;

  assign cur_line    = data_mem[req_idx];
  assign cur_tag     = tag_mem[req_idx];
  assign cur_word    = cur_line[int'(req_off)*32 +: 32];
  // An invalid line forces hit low, so uninitialised tags never leak into it.
  assign hit         = valid_q[req_idx] && (cur_tag == req_tag);
  assign victim_addr = {cur_tag, req_idx, {LOW_W{1'b0}}};
  assign fill_addr   = {req_tag, req_idx, {LOW_W{1'b0}}};

  assign cpu_rdata  = hit ? cur_word : 32'd0;
  assign cpu_stall  = (state_q != S_IDLE) || (cpu_req && !hit);
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

  // Merge the store bytes into the addressed word of the current line.
  always_comb begin
    store_line = cur_line;
    for (int b = 0; b < 4; b++) begin
      if (cpu_be[b]) begin
        store_line[int'(req_off)*32 + b*8 +: 8] = cpu_wdata[b*8 +: 8];
      end
    end
  end

  // Next-state, memory-port and counter logic.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d      = state_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    after_done_d = 1'b0;
    line_we      = 1'b0;
    tag_we       = 1'b0;
    line_wdata   = store_line;

    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          if (hit) begin
            if (cpu_we) begin
              line_we          = 1'b1;
              dirty_d[req_idx] = 1'b1;
            end
            if (!after_done_q) begin
              hit_count_d = hit_count_q + 32'd1;
            end
          end else begin
            miss_count_d = miss_count_q + 32'd1;
            mem_req_d    = 1'b1;
            if (valid_q[req_idx] && dirty_q[req_idx]) begin
              state_d     = S_WB;
              mem_we_d    = 1'b1;
              mem_addr_d  = victim_addr;
              mem_wdata_d = cur_line;
            end else begin
              state_d    = S_FILL;
              mem_we_d   = 1'b0;
              mem_addr_d = fill_addr;
            end
          end
        end
      end

      S_WB: begin
        // Dropping mem_req here gives memory its mandatory idle cycle before the fill.
        if (mem_ack) begin
          dirty_d[req_idx] = 1'b0;
          mem_req_d        = 1'b0;
          mem_we_d         = 1'b0;
          mem_addr_d       = fill_addr;
          state_d          = S_FILL;
        end
      end

      S_FILL: begin
        if (!mem_req_q) begin
          mem_req_d = 1'b1;
        end else if (mem_ack) begin
          line_we          = 1'b1;
          tag_we           = 1'b1;
          line_wdata       = mem_rdata;
          valid_d[req_idx] = 1'b1;
          dirty_d[req_idx] = 1'b0;
          mem_req_d        = 1'b0;
          state_d          = S_DONE;
        end
      end

      S_DONE: begin
        state_d      = S_IDLE;
        after_done_d = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Control state, valid/dirty bits, memory-port registers and counters.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      dirty_q      <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
      after_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      after_done_q <= after_done_d;
    end
  end

  // Tag and data array writes.
  always_ff @(posedge clk) begin
    // NOTE: the arrays carry no reset; cleared valid bits make their contents irrelevant.
    if (line_we) begin
      data_mem[req_idx] <= line_wdata;
    end
    if (tag_we) begin
      tag_mem[req_idx] <= req_tag;
    end
  end

endmodule

// File: tb/tb_l1_dcache.sv
// Testbench for l1_dcache: directed table for the cold-miss/hit/store flow,
// hand-written writeback, zero-wait and reset-abort sequences, then random
// traffic checked against an architectural memory model.
module tb_l1_dcache;

  localparam int LINES  = 64;
  localparam int WORDS  = 4;
  localparam int LINE_W = 32 * WORDS;

  logic              clk;
  logic              rst;
  logic              cpu_req;
  logic              cpu_we;
  logic [3:0]        cpu_be;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_stall;
  logic              mem_req;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [LINE_W-1:0] mem_rdata;
  logic [31:0]       hit_count;
  logic [31:0]       miss_count;

  l1_dcache #(.LINES(LINES), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_be    (cpu_be),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .hit_count (hit_count),
    .miss_count(miss_count)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Clock and cycle counter.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // ---------------- memory responder ----------------
  logic [31:0] main_mem [logic [31:0]];

  function automatic logic [31:0] main_rd(input logic [31:0] a);
    return main_mem.exists(a) ? main_mem[a] : init_word(a);
  endfunction

  typedef struct {
    bit                we;
    logic [31:0]       addr;
    logic [LINE_W-1:0] wdata;
    int                start_cyc;
    int                ack_cyc;
  } txn_t;

  txn_t txq[$];
  int   mem_lat  = 1;
  int   hold_err = 0;

  initial begin
    txn_t cur;
    int   rcnt;
    rcnt      = 0;
    cur       = '{0, 0, 0, 0, 0};
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req === 1'b1) begin
        if (rcnt == 0) begin
          cur.we        = mem_we;
          cur.addr      = mem_addr;
          cur.wdata     = mem_wdata;
          cur.start_cyc = cyc;
        end else if (mem_we !== cur.we || mem_addr !== cur.addr ||
                     (cur.we && mem_wdata !== cur.wdata)) begin
          hold_err++;
        end
        rcnt++;
        if (rcnt >= mem_lat) begin
          mem_ack     = 1'b1;
          cur.ack_cyc = cyc;
          for (int k = 0; k < WORDS; k++) begin
            if (cur.we) main_mem[cur.addr + 32'(4*k)] = cur.wdata[32*k +: 32];
            else        mem_rdata[32*k +: 32] = main_rd(cur.addr + 32'(4*k));
          end
          txq.push_back(cur);
          rcnt = 0;
        end
      end else begin
        rcnt = 0;
      end
    end
  end

  // ---------------- reference model ----------------
  // Architectural view (what loads must return) plus the expected memory image
  // and, per index, which tag is resident and whether it holds unwritten data.
  logic [31:0] arch      [logic [31:0]];
  logic [31:0] model_mem [logic [31:0]];
  bit          m_valid   [LINES];
  bit          m_dirty   [LINES];
  logic [21:0] m_tag     [LINES];
  logic [31:0] m_hits    = 0;
  logic [31:0] m_misses  = 0;
  int          m_txn     = 0;

  function automatic logic [31:0] mm_rd(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] arch_rd(input logic [31:0] a);
    return arch.exists(a) ? arch[a] : mm_rd(a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
    arch.delete();
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic model_access(input bit we, input logic [3:0] be, input logic [31:0] addr,
                              input logic [31:0] wdata, input int lat,
                              output logic [31:0] exp_rdata, output int exp_stall);
    int          idx;
    logic [21:0] tg;
    logic [31:0] wa;
    logic [31:0] base;
    logic [31:0] w;
    idx = int'(addr[9:4]);
    tg  = addr[31:10];
    wa  = {addr[31:2], 2'b00};
    if (m_valid[idx] && m_tag[idx] == tg) begin
      exp_stall = 0;
      m_hits++;
    end else begin
      m_misses++;
      if (m_valid[idx] && m_dirty[idx]) begin
        base = {m_tag[idx], addr[9:4], 4'b0000};
        for (int k = 0; k < WORDS; k++) model_mem[base + 32'(4*k)] = arch_rd(base + 32'(4*k));
        exp_stall = 2*lat + 3;
        m_txn += 2;
      end else begin
        exp_stall = lat + 2;
        m_txn += 1;
      end
      m_valid[idx] = 1;
      m_tag[idx]   = tg;
      m_dirty[idx] = 0;
    end
    exp_rdata = arch_rd(wa);
    if (we) begin
      w = exp_rdata;
      for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
      arch[wa]     = w;
      m_dirty[idx] = 1;
    end
  endtask

  // One CPU access, started at a negedge; returns at the negedge after completion.
  task automatic run_op(input bit we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, input int lat,
                        output logic [31:0] rdata, output int stalls,
                        output logic [31:0] exp_rdata, output int exp_stall);
    model_access(we, be, addr, wdata, lat, exp_rdata, exp_stall);
    mem_lat   = lat;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_be    = be;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    stalls    = 0;
    #1;
    while (cpu_stall !== 1'b0 && stalls < 100) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    rdata = cpu_rdata;
    @(negedge clk);
    cpu_req = 1'b0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk_rdata;
    logic [31:0] exp_rdata;
    int          exp_stall;
    logic [31:0] exp_hits;
    logic [31:0] exp_misses;
    int          exp_txn;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [31:0]       rd, erd;
    int                st, est, n;
    logic [LINE_W-1:0] wb_line;

    rst       = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_be    = 4'h0;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    model_reset();

    main_mem[32'h10]  = 32'hA000_0A00;
    main_mem[32'h14]  = 32'hA111_1A11;
    main_mem[32'h18]  = 32'hA222_2A22;
    main_mem[32'h1C]  = 32'hA333_3A33;
    model_mem[32'h10] = 32'hA000_0A00;
    model_mem[32'h14] = 32'hA111_1A11;
    model_mem[32'h18] = 32'hA222_2A22;
    model_mem[32'h1C] = 32'hA333_3A33;

    vecs[0] = '{0, 4'h0, 32'h10, 32'h0,         1, 32'hA000_0A00, 6, 0, 1, 1};
    vecs[1] = '{0, 4'h0, 32'h14, 32'h0,         1, 32'hA111_1A11, 0, 1, 1, 1};
    vecs[2] = '{0, 4'h0, 32'h18, 32'h0,         1, 32'hA222_2A22, 0, 2, 1, 1};
    vecs[3] = '{0, 4'h0, 32'h1C, 32'h0,         1, 32'hA333_3A33, 0, 3, 1, 1};
    vecs[4] = '{1, 4'h3, 32'h14, 32'hDEAD_BEEF, 0, 32'h0,         0, 4, 1, 1};
    vecs[5] = '{0, 4'h0, 32'h14, 32'h0,         1, 32'hA111_BEEF, 0, 5, 1, 1};

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall",     cpu_stall,  0);
    check("rst_mem_req",   mem_req,    0);
    check("rst_mem_we",    mem_we,     0);
    check("rst_mem_addr",  mem_addr,   0);
    check("rst_mem_wdata", mem_wdata,  0);
    check("rst_hits",      hit_count,  0);
    check("rst_misses",    miss_count, 0);
    check("rst_rdata",     cpu_rdata,  0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Cold miss, hits, partial store, load-back.
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, 4, rd, st, erd, est);
      if (vecs[i].chk_rdata) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_stall", i),  st,          vecs[i].exp_stall);
      check($sformatf("vec%0d_hits", i),   hit_count,   vecs[i].exp_hits);
      check($sformatf("vec%0d_misses", i), miss_count,  vecs[i].exp_misses);
      check($sformatf("vec%0d_txns", i),   txq.size(),  vecs[i].exp_txn);
    end
    if (txq.size() >= 1) begin
      check("cold_fill_we",   txq[0].we,   0);
      check("cold_fill_addr", txq[0].addr, 32'h10);
    end

    // Conflict miss on a dirty line: writeback, one idle cycle, then fill.
    wb_line = {32'hA333_3A33, 32'hA222_2A22, 32'hA111_BEEF, 32'hA000_0A00};
    run_op(0, 4'h0, 32'h410, 32'h0, 2, rd, st, erd, est);
    check("wb_rdata",  rd,         init_word(32'h410));
    check("wb_stall",  st,         7);
    check("wb_misses", miss_count, 2);
    check("wb_txns",   txq.size(), 3);
    if (txq.size() >= 3) begin
      check("wb_we",        txq[1].we,    1);
      check("wb_addr",      txq[1].addr,  32'h10);
      check("wb_wdata",     txq[1].wdata, wb_line);
      check("wb_fill_we",   txq[2].we,    0);
      check("wb_fill_addr", txq[2].addr,  32'h410);
      check("wb_gap",       txq[2].start_cyc - txq[1].ack_cyc, 2);
    end

    // Zero-wait memory on a clean miss.
    run_op(0, 4'h0, 32'h20, 32'h0, 1, rd, st, erd, est);
    check("zw_rdata",  rd,         init_word(32'h20));
    check("zw_stall",  st,         3);
    check("zw_misses", miss_count, 3);

    // Reset while a fill is outstanding.
    mem_lat   = 10;
    cpu_req   = 1'b1;
    cpu_we    = 1'b0;
    cpu_be    = 4'h0;
    cpu_addr  = 32'h30;
    cpu_wdata = 32'h0;
    n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rabort_req_up", mem_req, 1);
    @(negedge clk);
    check("rabort_pre_misses", miss_count, 4);
    #2 rst = 1'b1;
    #1;
    check("rabort_req_drop", mem_req,    0);
    check("rabort_misses0",  miss_count, 0);
    check("rabort_hits0",    hit_count,  0);
    @(negedge clk);
    rst     = 1'b0;
    cpu_req = 1'b0;
    model_reset();
    @(negedge clk);
    run_op(0, 4'h0, 32'h30, 32'h0, 2, rd, st, erd, est);
    check("rabort_rdata",  rd,         init_word(32'h30));
    check("rabort_stall",  st,         4);
    check("rabort_misses", miss_count, 1);

    // Random traffic over a few conflicting tags and indices.
    for (int i = 0; i < 300; i++) begin
      bit          we;
      logic [3:0]  be;
      logic [31:0] addr;
      int          lat;
      we   = 1'($urandom_range(0, 1));
      be   = 4'($urandom_range(0, 15));
      addr = {22'($urandom_range(0, 3)), 6'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      lat  = int'($urandom_range(1, 4));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      run_op(we, be, addr, $urandom, lat, rd, st, erd, est);
      if (!we) check($sformatf("rnd%0d_rdata", i), rd, erd);
      check($sformatf("rnd%0d_stall", i),  st,         est);
      check($sformatf("rnd%0d_hits", i),   hit_count,  m_hits);
      check($sformatf("rnd%0d_misses", i), miss_count, m_misses);
    end

    check("total_txns", txq.size(), m_txn);
    check("mem_hold",   hold_err,   0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
